// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC select encoding and default parameters
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_RET  = 3'd1,
        SEL_CALL = 3'd2,
        SEL_BR   = 3'd3,
        SEL_INC  = 3'd4
    } pc_sel_e;

    localparam int unsigned DEF_RESET_VEC = 0;
    localparam int unsigned DEF_INC       = 4;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; overflow overwrites the oldest entry
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         push,
    input  logic         pop,
    input  logic [0:W-1] push_data,
    output logic [0:W-1] top,
    output logic         empty,
    output logic         full,
    output logic         err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ptr addresses the next free slot; the top entry sits one below it
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic [0:W-1]     mem [DEPTH];

    assign top   = mem[ptr - PTR_W'(1)];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            err <= 1'b0;
            if (!hold) begin
                if (pop) begin
                    if (empty) begin
                        err <= 1'b1;
                    end else begin
                        ptr   <= ptr - PTR_W'(1);
                        count <= count - CNT_W'(1);
                    end
                end else if (push) begin
                    mem[ptr] <= push_data;
                    ptr      <= ptr + PTR_W'(1);
                    if (full) begin
                        err <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/program_counter3.sv
// rtl/program_counter3.sv - fetch-stage program counter with branch, call/return and RAS
module program_counter3
    import pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int unsigned     INC       = DEF_INC,
    parameter logic [0:PC_W-1] RESET_VEC = PC_W'(DEF_RESET_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_en,
    input  logic [0:PC_W-1] branch_tgt,
    input  logic            call_en,
    input  logic            ret_en,
    output logic [0:PC_W-1] next_pc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    pc_sel_e         sel;
    logic [0:PC_W-1] pc_inc;
    logic [0:PC_W-1] ras_top;

    always_comb begin
        sel = SEL_INC;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret_en) begin
            sel = SEL_RET;
        end else if (call_en) begin
            sel = SEL_CALL;
        end else if (branch_en) begin
            sel = SEL_BR;
        end
    end

    assign pc_inc = next_pc + PC_W'(INC);

    // A return on an empty stack falls through to a sequential advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc <= RESET_VEC;
        end else begin
            case (sel)
                SEL_HOLD: next_pc <= next_pc;
                SEL_RET:  next_pc <= ras_empty ? pc_inc : ras_top;
                SEL_CALL: next_pc <= branch_tgt;
                SEL_BR:   next_pc <= branch_tgt;
                default:  next_pc <= pc_inc;
            endcase
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .hold      (sel == SEL_HOLD),
        .push      (sel == SEL_CALL),
        .pop       (sel == SEL_RET),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .err       (ras_err)
    );

endmodule

// File: tb/tb_program_counter3.sv
// tb/tb_program_counter3.sv - scoreboard bench for program_counter3 with a queue-based reference model
module tb_program_counter3;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_en;
    logic [31:0] branch_tgt;
    logic        call_en;
    logic        ret_en;
    logic [31:0] next_pc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    program_counter3 dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_tgt (branch_tgt),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .next_pc    (next_pc),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_err    (ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_ras[$];
    logic [31:0] m_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stack is a plain queue; overflow drops the oldest element
    task automatic model_step(input logic s, input logic r, input logic c, input logic b,
                              input logic [31:0] t);
        exp_t        e;
        logic [31:0] dropped;
        e.err = 1'b0;
        if (!s) begin
            if (r) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin
                    m_pc  = m_pc + 32'd4;
                    e.err = 1'b1;
                end
            end else if (c) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) begin
                    dropped = m_ras.pop_front();
                    e.err   = 1'b1;
                end
                m_pc = t;
            end else if (b) begin
                m_pc = t;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        e.pc    = m_pc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        sbq.push_back(e);
    endtask

    task automatic cycle(input logic s, input logic r, input logic c, input logic b,
                         input logic [31:0] t);
        @(negedge clk);
        stall      = s;
        ret_en     = r;
        call_en    = c;
        branch_en  = b;
        branch_tgt = t;
        model_step(s, r, c, b, t);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Reset asserted mid-cycle, optionally while a call is being requested
    task automatic do_reset(input logic with_call);
        @(negedge clk);
        stall      = 1'b0;
        ret_en     = 1'b0;
        branch_en  = 1'b0;
        call_en    = with_call;
        branch_tgt = 32'd900;
        #2 rst = 1'b1;
        #1;
        chk("rst_pc", next_pc, 32'd0);
        chk("rst_empty", ras_empty, 1'b1);
        chk("rst_full", ras_full, 1'b0);
        chk("rst_err", ras_err, 1'b0);
        m_pc = 32'd0;
        m_ras.delete();
        @(posedge clk);
        #2;
        rst     = 1'b0;
        call_en = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_pc", next_pc, e.pc);
            chk("sb_empty", ras_empty, e.empty);
            chk("sb_full", ras_full, e.full);
            chk("sb_err", ras_err, e.err);
        end
    end

    initial begin
        logic [31:0] t;
        rst        = 1'b1;
        stall      = 1'b0;
        branch_en  = 1'b0;
        branch_tgt = 32'd0;
        call_en    = 1'b0;
        ret_en     = 1'b0;
        m_pc       = 32'd0;
        #19;
        chk("init_pc", next_pc, 32'd0);
        chk("init_empty", ras_empty, 1'b1);
        chk("init_full", ras_full, 1'b0);
        chk("init_err", ras_err, 1'b0);
        rst = 1'b0;

        idle(15);
        chk("freerun_60", next_pc, 32'd60);
        chk("freerun_empty", ras_empty, 1'b1);

        do_reset(1'b0);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            chk("stall_hold", next_pc, 32'd12);
        end
        idle(1);
        chk("stall_resume", next_pc, 32'd16);

        do_reset(1'b0);
        idle(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd200);
        chk("branch_tgt", next_pc, 32'd200);
        idle(1);
        chk("branch_inc", next_pc, 32'd204);
        chk("branch_ras", ras_empty, 1'b1);

        do_reset(1'b0);
        idle(4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd400);
        chk("call_tgt", next_pc, 32'd400);
        idle(1);
        chk("call_inc", next_pc, 32'd404);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("ret_pc", next_pc, 32'd20);
        chk("ret_empty", ras_empty, 1'b1);

        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'(i * 100));
            chk("nest_err_clear", ras_err, 1'b0);
        end
        chk("nest_full", ras_full, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd500);
        chk("overflow_err", ras_err, 1'b1);
        chk("overflow_full", ras_full, 1'b1);
        for (int i = 4; i >= 1; i--) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            chk("unwind_pc", next_pc, 32'(i * 100 + 4));
        end
        chk("unwind_empty", ras_empty, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("underflow_err", ras_err, 1'b1);
        chk("underflow_pc", next_pc, 32'd108);
        idle(1);
        chk("underflow_err_clear", ras_err, 1'b0);

        do_reset(1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        idle(1);
        chk("wrap_zero", next_pc, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'd64);
        chk("prio_ret_over_call", next_pc, 32'd4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd40);
        chk("call_not_empty", ras_empty, 1'b0);
        do_reset(1'b1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                else t = $urandom & 32'hFFFF_FFFC;
                cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), t);
            end
        end

        @(posedge clk);
        #2;
        chk("sb_drain", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
